// File: rtl/limber_gnrl_pkg.sv
// Shared definitions for the Limber general-purpose library: default queue
// sizing and small sizing helpers.

package limber_gnrl_pkg;

    // Default data width and depth used by the MCU response/fetch queues.
    localparam int LIMBER_GNRL_DW_DFLT = 32;
    localparam int LIMBER_GNRL_DP_DFLT = 4;

    // Width of an index that addresses dp entries; a single-entry
    // structure still gets a 1-bit pointer so no vector is zero-width.
    function automatic int limber_gnrl_ptr_w(input int dp);
        if (dp > 1) begin
            return $clog2(dp);
        end
        return 1;
    endfunction

endpackage : limber_gnrl_pkg

// File: rtl/limber_gnrl_dfflr.sv
// Load-enable flop with asynchronous active-low reset to zero. Used as the
// single storage primitive for FIFO entries, pointers and counters.

module limber_gnrl_dfflr
    import limber_gnrl_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture i_d when enabled; clear to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule : limber_gnrl_dfflr

// File: rtl/limber_gnrl_fifo.sv
// Synchronous valid/ready FIFO. Entries, pointers and occupancy are all
// load-enable flops; the head entry is read combinationally from storage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on that side; valid may not depend on ready, the producer holds
// i_vld/i_dat until taken, and the FIFO holds o_vld/o_dat while stalled.

module limber_gnrl_fifo
    import limber_gnrl_pkg::*;
#(
    parameter int DW        = LIMBER_GNRL_DW_DFLT,
    parameter int DP        = LIMBER_GNRL_DP_DFLT,
    parameter int CUT_READY = 1,
    parameter int CW        = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] o_cnt
);

    localparam int            PW       = limber_gnrl_ptr_w(DP);
    localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DP);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_mem [DP];

    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cnt_en;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;
    logic [DP-1:0] w_mem_en;

    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == '0);

    // With CUT_READY=0 a full FIFO can still accept when the head leaves in
    // the same cycle, at the cost of an o_rdy -> i_rdy combinational path.
    assign i_rdy = (!w_full) || ((CUT_READY == 0) && o_rdy);
    assign o_vld = !w_empty;
    assign o_dat = r_mem[r_rptr];
    assign o_cnt = r_cnt;

    assign w_wr = i_vld && i_rdy;
    assign w_rd = o_vld && o_rdy;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (r_wptr == PTR_LAST) begin
            w_wptr_nxt = '0;
        end else begin
            w_wptr_nxt = r_wptr + PW'(1);
        end
        if (r_rptr == PTR_LAST) begin
            w_rptr_nxt = '0;
        end else begin
            w_rptr_nxt = r_rptr + PW'(1);
        end
    end

    // Occupancy changes only when exactly one side fires.
    always_comb begin
        w_cnt_en  = w_wr ^ w_rd;
        w_cnt_nxt = r_cnt;
        if (w_wr) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    limber_gnrl_dfflr #(.W(PW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_wr),
        .i_d   (w_wptr_nxt),
        .o_q   (r_wptr)
    );

    limber_gnrl_dfflr #(.W(PW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_rd),
        .i_d   (w_rptr_nxt),
        .o_q   (r_rptr)
    );

    limber_gnrl_dfflr #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cnt_en),
        .i_d   (w_cnt_nxt),
        .o_q   (r_cnt)
    );

    // One flop bank per entry, loaded only when the write pointer selects it.
    for (genvar gi = 0; gi < DP; gi++) begin : g_mem
        assign w_mem_en[gi] = w_wr && (r_wptr == PW'(gi));

        limber_gnrl_dfflr #(.W(DW)) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_mem_en[gi]),
            .i_d   (i_dat),
            .o_q   (r_mem[gi])
        );
    end

`ifndef SYNTHESIS
`ifdef LIMBER_GNRL_ASSERT
    // Simulation checks on handshake legality and unknown control inputs.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(i_vld));
            assert (!$isunknown(o_rdy));
            assert (!(w_wr && w_full && !w_rd));
            assert (!(w_rd && w_empty));
        end
    end
`endif
`endif

endmodule : limber_gnrl_fifo
